// File: rtl/hazard_forward_unit.sv
// EX-stage forwarding control: operand-mux selects from a shadow pipeline of destination info,
// plus load-use stall, wrong-path flush and saturating event counters.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  branch_mispredict,
    output logic [1:0]            fwd_sel_a,
    output logic [1:0]            fwd_sel_b,
    output logic                  stall,
    output logic                  flush_id,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_WB  = 2'b01;
    localparam logic [1:0] SEL_MEM = 2'b10;

    logic                  ex_vld, ex_we, ex_ld, ex_use1, ex_use2;
    logic [REG_ADDR_W-1:0] ex_rd, ex_rs1, ex_rs2;
    logic                  mem_vld, mem_we, mem_ld;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  wb_vld, wb_we;
    logic [REG_ADDR_W-1:0] wb_rd;

    logic hz;
    logic bubble;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic ev);
        if (!ev || c == '1)
            return c;
        return c + CNT_W'(1);
    endfunction

    // Youngest producer wins; a load in EX/MEM cannot supply an ALU result yet.
    function automatic logic [1:0] fwd_select(
        input logic [REG_ADDR_W-1:0] rs,
        input logic                  use_rs,
        input logic                  m_vld,
        input logic                  m_we,
        input logic                  m_ld,
        input logic [REG_ADDR_W-1:0] m_rd,
        input logic                  w_vld,
        input logic                  w_we,
        input logic [REG_ADDR_W-1:0] w_rd
    );
        if (use_rs && m_vld && m_we && !m_ld && m_rd != '0 && m_rd == rs)
            return SEL_MEM;
        if (use_rs && w_vld && w_we && w_rd != '0 && w_rd == rs)
            return SEL_WB;
        return SEL_RF;
    endfunction

    assign hz = id_valid && ex_vld && ex_ld && ex_we && (ex_rd != '0) &&
                ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

    assign stall    = hz && !branch_mispredict;
    assign flush_id = branch_mispredict;
    assign bubble   = stall || branch_mispredict || !id_valid;

    assign fwd_sel_a = fwd_select(ex_rs1, ex_use1, mem_vld, mem_we, mem_ld, mem_rd,
                                  wb_vld, wb_we, wb_rd);
    assign fwd_sel_b = fwd_select(ex_rs2, ex_use2, mem_vld, mem_we, mem_ld, mem_rd,
                                  wb_vld, wb_we, wb_rd);

    // ID -> EX -> MEM -> WB shadow pipeline, control bits
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_vld    <= 1'b0;
            ex_use1   <= 1'b0;
            ex_use2   <= 1'b0;
            mem_vld   <= 1'b0;
            wb_vld    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            ex_vld    <= !bubble;
            ex_use1   <= !bubble && id_use_rs1;
            ex_use2   <= !bubble && id_use_rs2;
            mem_vld   <= ex_vld;
            wb_vld    <= mem_vld;
            stall_cnt <= sat_inc(stall_cnt, stall);
            flush_cnt <= sat_inc(flush_cnt, flush_id);
        end
    end

    // ID -> EX -> MEM -> WB shadow pipeline, destination/source fields (qualified by *_vld)
    always_ff @(posedge clk) begin
        ex_rd  <= id_rd;
        ex_we  <= id_reg_write;
        ex_ld  <= id_mem_read;
        ex_rs1 <= id_rs1;
        ex_rs2 <= id_rs2;
        mem_rd <= ex_rd;
        mem_we <= ex_we;
        mem_ld <= ex_ld;
        wb_rd  <= mem_rd;
        wb_we  <= mem_we;
    end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed instruction table, then random traffic against a
// reference model that tracks the last three issued instructions.
module tb_hazard_forward_unit;

    localparam int AW    = 5;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;
    localparam int NRAND = 600;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2, id_reg_write, id_mem_read;
    logic          branch_mispredict;
    logic [1:0]    fwd_sel_a, fwd_sel_b;
    logic          stall, flush_id;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    hazard_forward_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .branch_mispredict(branch_mispredict), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .stall(stall), .flush_id(flush_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst, v;
        logic [AW-1:0] rs1, rs2;
        logic u1, u2;
        logic [AW-1:0] rd;
        logic we, ld, mis;
        int ea, eb, es, ef, esc, efc;
    } vec_t;

    typedef struct {
        logic vld, we, ld, u1, u2;
        logic [AW-1:0] rd, rs1, rs2;
    } ins_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, int rs1, int rs2, logic u1, logic u2, int rd,
                                logic we, logic ld, logic mis,
                                int ea, int eb, int es, int ef, int esc, int efc);
        vec_t t;
        t.rst = r; t.v = v; t.rs1 = AW'(rs1); t.rs2 = AW'(rs2); t.u1 = u1; t.u2 = u2;
        t.rd = AW'(rd); t.we = we; t.ld = ld; t.mis = mis;
        t.ea = ea; t.eb = eb; t.es = es; t.ef = ef; t.esc = esc; t.efc = efc;
        return t;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.v; id_rs1 = t.rs1; id_rs2 = t.rs2;
        id_use_rs1 = t.u1; id_use_rs2 = t.u2; id_rd = t.rd;
        id_reg_write = t.we; id_mem_read = t.ld; branch_mispredict = t.mis;
    endtask

    // Reference: which older in-flight instruction (if any) supplies register r
    function automatic int ref_sel(input ins_t h[3], input logic [AW-1:0] r, input logic u);
        if (!h[0].vld || !u || r == 0) return 0;
        if (h[1].vld && h[1].we && !h[1].ld && h[1].rd == r) return 2;
        if (h[2].vld && h[2].we && h[2].rd == r) return 1;
        return 0;
    endfunction

    initial begin
        vec_t t;
        vec_t idle;
        ins_t h[3];
        ins_t nw;
        int msc, mfc, ehz, es;
        logic held;

        idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0);
        t = idle; t.rst = 1'b1;
        drive(t);
        repeat (2) @(posedge clk);
        #1 drive(idle);
        @(negedge clk);
        chk("reset sel_a", int'(fwd_sel_a), 0);
        chk("reset sel_b", int'(fwd_sel_b), 0);
        chk("reset stall", int'(stall), 0);
        chk("reset flush", int'(flush_id), 0);
        chk("reset stall_cnt", int'(stall_cnt), 0);
        chk("reset flush_cnt", int'(flush_cnt), 0);

        // T1 ALU back-to-back
        tbl.push_back(mk(0,1,1,2,1,1,5,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,5,1,1,1,6,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 2,0,0,0,0,0));
        // T2 distance 2
        tbl.push_back(mk(0,1,1,2,1,1,5,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,2,5,1,1,7,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,1,0,0,0,0));
        // T3 double producer
        tbl.push_back(mk(0,1,1,2,1,1,5,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,5,0,1,0,5,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,5,5,1,1,8,1,0,0, 2,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 2,2,0,0,0,0));
        // T4 load-use
        tbl.push_back(mk(0,1,1,0,1,0,7,1,1,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,1,7,3,1,1,9,1,0,0, 0,0,1,0,0,0));
        tbl.push_back(mk(0,1,7,3,1,1,9,1,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 1,0,0,0,1,0));
        // T5 x0 and unused sources
        tbl.push_back(mk(0,1,1,0,1,0,0,1,1,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,0,0,1,1,1,1,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,1,1,0,0,4,1,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,0));
        // T6 mispredict together with load-use
        tbl.push_back(mk(0,1,1,0,1,0,7,1,1,0, 0,0,0,0,1,0));
        tbl.push_back(mk(0,1,7,3,1,1,9,1,0,1, 0,0,0,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,1,1));
        // T7 reset during a load-use stall
        tbl.push_back(mk(0,1,1,0,1,0,7,1,1,0, 0,0,0,0,1,1));
        tbl.push_back(mk(1,1,7,3,1,1,9,1,0,0, 0,0,1,0,1,1));
        tbl.push_back(mk(0,1,7,3,1,1,9,1,0,0, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1 drive(tbl[i]);
            @(negedge clk);
            chk($sformatf("row%0d sel_a", i), int'(fwd_sel_a), tbl[i].ea);
            chk($sformatf("row%0d sel_b", i), int'(fwd_sel_b), tbl[i].eb);
            chk($sformatf("row%0d stall", i), int'(stall), tbl[i].es);
            chk($sformatf("row%0d flush", i), int'(flush_id), tbl[i].ef);
            chk($sformatf("row%0d stall_cnt", i), int'(stall_cnt), tbl[i].esc);
            chk($sformatf("row%0d flush_cnt", i), int'(flush_cnt), tbl[i].efc);
        end

        // Random traffic; the first cycle resets so model and DUT start aligned
        for (int k = 0; k < 3; k++) h[k] = '{default: '0};
        msc = 0; mfc = 0; held = 1'b0;
        t = idle;
        for (int n = 0; n < NRAND; n++) begin
            if (!held) begin
                t.v  = ($urandom_range(3) != 0);
                t.rs1 = AW'($urandom_range(3)); t.rs2 = AW'($urandom_range(3));
                t.rd  = AW'($urandom_range(3));
                t.u1 = 1'($urandom); t.u2 = 1'($urandom); t.we = 1'($urandom);
                t.ld = ($urandom_range(2) == 0);
            end
            t.mis = ($urandom_range(7) == 0);
            t.rst = (n == 0) || ($urandom_range(79) == 0);
            @(posedge clk);
            #1 drive(t);
            @(negedge clk);

            ehz = (t.v && h[0].vld && h[0].ld && h[0].we && h[0].rd != 0 &&
                   ((t.u1 && t.rs1 == h[0].rd) || (t.u2 && t.rs2 == h[0].rd))) ? 1 : 0;
            es = (ehz == 1 && !t.mis) ? 1 : 0;
            if (n > 0) begin
                chk($sformatf("rand%0d sel_a", n), int'(fwd_sel_a), ref_sel(h, h[0].rs1, h[0].u1));
                chk($sformatf("rand%0d sel_b", n), int'(fwd_sel_b), ref_sel(h, h[0].rs2, h[0].u2));
                chk($sformatf("rand%0d stall", n), int'(stall), es);
                chk($sformatf("rand%0d flush", n), int'(flush_id), int'(t.mis));
                chk($sformatf("rand%0d stall_cnt", n), int'(stall_cnt), msc);
                chk($sformatf("rand%0d flush_cnt", n), int'(flush_cnt), mfc);
                if (h[0].vld && h[1].vld && h[1].ld && h[1].we && h[1].rd != 0 &&
                    ((h[0].u1 && h[0].rs1 == h[1].rd) || (h[0].u2 && h[0].rs2 == h[1].rd))) begin
                    chk($sformatf("rand%0d load in EX/MEM feeding EX", n), 1, 0);
                end
            end

            if (t.rst) begin
                for (int k = 0; k < 3; k++) h[k].vld = 1'b0;
                msc = 0; mfc = 0;
                held = 1'b0;
            end else begin
                if (es == 1 && msc < CMAX) msc++;
                if (t.mis && mfc < CMAX) mfc++;
                nw.vld = t.v && es == 0 && !t.mis;
                nw.we = t.we; nw.ld = t.ld; nw.u1 = t.u1; nw.u2 = t.u2;
                nw.rd = t.rd; nw.rs1 = t.rs1; nw.rs2 = t.rs2;
                h[2] = h[1]; h[1] = h[0]; h[0] = nw;
                held = (es == 1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
